// File: rtl/uart_pkg.sv
// Shared UART definitions: RX state encodings, oversampling constants,
// word-length encodings and the parity helper used by both TX and RX blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE     = 3'd0,
    RX_START    = 3'd1,
    RX_DATA     = 3'd2,
    RX_PARITY   = 3'd3,
    RX_STOP     = 3'd4,
    RX_BRK_WAIT = 3'd5
  } rx_state_t;

  localparam logic [4:0] OSR_16 = 5'd16;
  localparam logic [4:0] OSR_13 = 5'd13;
  localparam logic [4:0] MID_16 = 5'd7;
  localparam logic [4:0] MID_13 = 5'd5;

  localparam logic [1:0] WLS_5 = 2'd0;
  localparam logic [1:0] WLS_6 = 2'd1;
  localparam logic [1:0] WLS_7 = 2'd2;
  localparam logic [1:0] WLS_8 = 2'd3;

  // Stick parity forces ~esp; otherwise esp=1 gives even parity over the word.
  function automatic logic parity_expected(input logic [7:0] data,
                                           input logic [1:0] wls,
                                           input logic       esp,
                                           input logic       sp);
    logic [7:0] mask;
    logic       result;
    case (wls)
      WLS_5:   mask = 8'h1F;
      WLS_6:   mask = 8'h3F;
      WLS_7:   mask = 8'h7F;
      default: mask = 8'hFF;
    endcase
    if (sp) result = ~esp;
    else    result = (^(data & mask)) ^ ~esp;
    return result;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous RX line plus falling-edge detect.
// The chain and edge history reset to 1 (line idle).
module uart_rx_sync
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic srst,
  input  logic serial,
  output logic rx_sync,
  output logic fall_pulse
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      sync_reg <= '1;
      prev_reg <= 1'b1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], serial};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign rx_sync    = sync_reg[SYNC_STAGES-1];
  assign fall_pulse = prev_reg & ~rx_sync;

endmodule

// File: rtl/uart_rx_shift.sv
// UART receive deserializer on the 16x/13x oversample clock.
// Optional 2-of-3 majority sampling: define UART_RX_MAJORITY_VOTE_EN.
module uart_rx_shift
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       bclk_in,
  input  logic       rst_in,
  input  logic       enable_in,
  input  logic       serial_in,
  input  logic       osm_sel_in,
  input  logic [1:0] wls_in,
  input  logic       stb_in,
  input  logic       pen_in,
  input  logic       esp_in,
  input  logic       sp_in,
  output logic [7:0] rbr_out,
  output logic       rx_valid_out,
  output logic       parity_err_out,
  output logic       framing_err_out,
  output logic       break_out,
  output logic       busy_out
);

  logic rx_sync;
  logic fall_pulse;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (bclk_in),
    .srst       (rst_in),
    .serial     (serial_in),
    .rx_sync    (rx_sync),
    .fall_pulse (fall_pulse)
  );

  logic [4:0] n_val;
  logic [4:0] mid_val;
  logic [4:0] start_pt;
  logic       bit_val;

  assign n_val   = osm_sel_in ? OSR_13 : OSR_16;
  assign mid_val = osm_sel_in ? MID_13 : MID_16;

`ifdef UART_RX_MAJORITY_VOTE_EN
  // Vote taken one cycle past the sample point; delaying the start decision
  // shifts every later sample point by the same cycle.
  logic [1:0] hist_reg;
  always_ff @(posedge bclk_in) begin
    if (rst_in) hist_reg <= 2'b11;
    else        hist_reg <= {hist_reg[0], rx_sync};
  end
  assign bit_val  = (hist_reg[1] & hist_reg[0]) | (hist_reg[1] & rx_sync) |
                    (hist_reg[0] & rx_sync);
  assign start_pt = mid_val + 5'd1;
`else
  assign bit_val  = rx_sync;
  assign start_pt = mid_val;
`endif

  // Only the first stop bit is ever checked, so the stop-length select has no effect here.
  logic unused_stb;
  assign unused_stb = stb_in;

  rx_state_t  state_reg, state_next;
  logic [4:0] cc_reg, cc_next;
  logic [2:0] bc_reg, bc_next;
  logic [7:0] shift_reg, shift_next;
  logic       par_reg, par_next;
  logic [7:0] rbr_reg, rbr_next;
  logic       valid_reg, valid_next;
  logic       pe_reg, pe_next;
  logic       fe_reg, fe_next;
  logic       bi_reg, bi_next;

  logic       at_end;
  logic       last_bit;
  logic       is_break;

  always_ff @(posedge bclk_in) begin
    if (rst_in) begin
      state_reg <= RX_IDLE;
      cc_reg    <= '0;
      bc_reg    <= '0;
      shift_reg <= '0;
      par_reg   <= 1'b0;
      rbr_reg   <= '0;
      valid_reg <= 1'b0;
      pe_reg    <= 1'b0;
      fe_reg    <= 1'b0;
      bi_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cc_reg    <= cc_next;
      bc_reg    <= bc_next;
      shift_reg <= shift_next;
      par_reg   <= par_next;
      rbr_reg   <= rbr_next;
      valid_reg <= valid_next;
      pe_reg    <= pe_next;
      fe_reg    <= fe_next;
      bi_reg    <= bi_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cc_next    = cc_reg;
    bc_next    = bc_reg;
    shift_next = shift_reg;
    par_next   = par_reg;
    rbr_next   = rbr_reg;
    valid_next = 1'b0;
    pe_next    = pe_reg;
    fe_next    = fe_reg;
    bi_next    = bi_reg;

    at_end   = (cc_reg == (n_val - 5'd1));
    last_bit = (bc_reg == ({1'b0, wls_in} + 3'd4));
    // Break: every sampled bit of the frame, stop included, was 0.
    is_break = (shift_reg == 8'd0) && !bit_val && (!pen_in || !par_reg);

    if (!enable_in) begin
      state_next = RX_IDLE;
      cc_next    = '0;
      bc_next    = '0;
    end else begin
      case (state_reg)
        RX_IDLE: begin
          if (fall_pulse) begin
            state_next = RX_START;
            cc_next    = '0;
          end
        end
        RX_START: begin
          if (cc_reg == start_pt) begin
            cc_next = '0;
            if (bit_val) begin
              state_next = RX_IDLE;
            end else begin
              state_next = RX_DATA;
              bc_next    = '0;
              shift_next = '0;
              par_next   = 1'b0;
            end
          end else begin
            cc_next = cc_reg + 5'd1;
          end
        end
        RX_DATA: begin
          if (at_end) begin
            shift_next[bc_reg] = bit_val;
            cc_next            = '0;
            if (last_bit) begin
              bc_next    = '0;
              state_next = pen_in ? RX_PARITY : RX_STOP;
            end else begin
              bc_next = bc_reg + 3'd1;
            end
          end else begin
            cc_next = cc_reg + 5'd1;
          end
        end
        RX_PARITY: begin
          if (at_end) begin
            par_next   = bit_val;
            cc_next    = '0;
            state_next = RX_STOP;
          end else begin
            cc_next = cc_reg + 5'd1;
          end
        end
        RX_STOP: begin
          if (at_end) begin
            cc_next    = '0;
            valid_next = 1'b1;
            rbr_next   = shift_reg;
            pe_next    = pen_in & (par_reg ^ parity_expected(shift_reg, wls_in, esp_in, sp_in));
            fe_next    = ~bit_val;
            bi_next    = is_break;
            state_next = is_break ? RX_BRK_WAIT : RX_IDLE;
          end else begin
            cc_next = cc_reg + 5'd1;
          end
        end
        RX_BRK_WAIT: begin
          if (rx_sync) state_next = RX_IDLE;
        end
        default: state_next = RX_IDLE;
      endcase
    end
  end

  assign rbr_out         = rbr_reg;
  assign rx_valid_out    = valid_reg;
  assign parity_err_out  = pe_reg;
  assign framing_err_out = fe_reg;
  assign break_out       = bi_reg;
  assign busy_out        = (state_reg != RX_IDLE);

endmodule
